spi_storage_controller: RTL and testbench

- Parametrised next-generation storage controller between the core memory port and storage.
- Word addresses below SRAM_WORDS are served by an internal byte-enabled SRAM. Addresses at or above SRAM_WORDS are served by an external SPI flash, which is read-only.
- Supports READ (0x03) or FAST_READ (0x0B + dummy cycles), 3- or 4-byte flash addressing and a programmable SCK divider.
- A programming mode routes the external SPI pins straight to a programming SPI port.

---
 rtl/storage_pkg.sv | 22 ++
 rtl/spi_shift_engine.sv | 89 ++++++++
 rtl/spi_storage_controller.sv | 140 ++++++++++++++
 tb/tb_spi_storage_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/storage_pkg.sv
// Shared opcodes, controller state encoding and SPI frame length helper
// for the storage controller.
package storage_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        IDLE,
        SRAM_ACC,
        SPI_XFER,
        DONE,
        PROG
    } storage_state_t;

    // SCK cycles in one flash read: opcode, address, optional dummy, data.
    function automatic int spi_total_bits(input int addr_bytes, input int fast_read,
                                          input int dummy_cycles, input int data_w);
        return 8 + 8 * addr_bytes + ((fast_read != 0) ? dummy_cycles : 0) + data_w;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI master for a single flash read: divider, cs/sck/mosi generation,
// command shift-out and data shift-in, with a start/busy/done handshake.
module spi_shift_engine
    import storage_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int SCK_DIV      = 2,
    parameter int ADDR_BYTES   = 3,
    parameter int FAST_READ    = 0,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*ADDR_BYTES-1:0] addr,
    output logic                    busy,
    output logic                    done,
    output logic                    cs_n,
    output logic                    sck,
    output logic                    mosi,
    input  logic                    miso,
    output logic [DATA_W-1:0]       rx_data
);

    localparam int DUMMY = (FAST_READ != 0) ? DUMMY_CYCLES : 0;
    localparam int TX_W  = 8 + 8 * ADDR_BYTES + DUMMY;
    localparam int TOTAL = spi_total_bits(ADDR_BYTES, FAST_READ, DUMMY_CYCLES, DATA_W);
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int DW    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [7:0] OPCODE = (FAST_READ != 0) ? OP_FAST_READ : OP_READ;

    logic [TX_W-1:0] frame;
    logic [TX_W-1:0] tx_sr;
    logic [DW-1:0]   div;
    logic [CW-1:0]   bit_cnt;
    logic            active;
    logic            tick;

    // Dummy bits are the zero tail of the frame; data phase shifts out zeros too.
    assign frame = TX_W'({OPCODE, addr}) << DUMMY;
    assign tick  = (div == DW'(SCK_DIV - 1));
    assign busy  = active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active  <= 1'b0;
            done    <= 1'b0;
            cs_n    <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_data <= '0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active  <= 1'b1;
                    cs_n    <= 1'b0;
                    mosi    <= frame[TX_W-1];
                    tx_sr   <= frame << 1;
                    div     <= '0;
                    bit_cnt <= '0;
                end
            end else begin
                div <= tick ? '0 : div + 1'b1;
                if (tick) begin
                    if (sck) begin
                        sck     <= 1'b0;
                        mosi    <= tx_sr[TX_W-1];
                        tx_sr   <= tx_sr << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (bit_cnt == CW'(TOTAL)) begin
                        // one half-period after the last falling edge
                        cs_n   <= 1'b1;
                        mosi   <= 1'b0;
                        active <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        sck     <= 1'b1;
                        rx_data <= {rx_data[DATA_W-2:0], miso};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_storage_controller.sv
// Storage controller: low word addresses hit an internal byte-enabled SRAM,
// the rest read an external SPI flash; programming mode bypasses to a host port.
module spi_storage_controller
    import storage_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int SRAM_WORDS   = 2048,
    parameter int SCK_DIV      = 2,
    parameter int ADDR_BYTES   = 3,
    parameter int FAST_READ    = 0,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memory_access,
    input  logic                memory_is_writing,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   d_in,
    input  logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   d_out,
    output logic                out_valid,
    input  logic                set_programming_mode,
    output logic                external_storage_spi_cs_n,
    output logic                external_storage_spi_sck,
    output logic                external_storage_spi_mosi,
    input  logic                external_storage_spi_miso,
    input  logic                programming_spi_cs_n,
    input  logic                programming_spi_sck,
    input  logic                programming_spi_mosi,
    output logic                programming_spi_miso
);

    localparam int AW = $clog2(SRAM_WORDS);
    localparam int NB = DATA_W / 8;

    storage_state_t          state;
    logic                    prog_mode;
    logic                    spi_start;
    logic                    spi_busy;
    logic                    spi_done;
    logic [8*ADDR_BYTES-1:0] spi_addr;
    logic [DATA_W-1:0]       spi_rx;
    logic                    eng_cs_n;
    logic                    eng_sck;
    logic                    eng_mosi;
    logic                    in_sram;
    logic                    sram_we;
    logic [DATA_W-1:0]       mem [SRAM_WORDS];

    assign in_sram = (addr < 32'(SRAM_WORDS));
    assign sram_we = (state == IDLE) && !set_programming_mode && memory_access
                     && in_sram && memory_is_writing;

    always_ff @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) mem[addr[AW-1:0]][8*b +: 8] <= d_in[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            prog_mode <= 1'b0;
            d_out     <= '0;
            out_valid <= 1'b0;
            spi_start <= 1'b0;
            spi_addr  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (set_programming_mode) begin
                        state     <= PROG;
                        prog_mode <= 1'b1;
                    end else if (memory_access) begin
                        if (in_sram) begin
                            state     <= SRAM_ACC;
                            out_valid <= 1'b1;
                            if (!memory_is_writing) d_out <= mem[addr[AW-1:0]];
                        end else if (!memory_is_writing) begin
                            state     <= SPI_XFER;
                            spi_start <= 1'b1;
                            spi_addr  <= addr[8*ADDR_BYTES-1:0];
                        end else begin
                            // flash is read-only: acknowledge and drop the write
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SRAM_ACC: state <= DONE;
                SPI_XFER: begin
                    if (spi_busy) spi_start <= 1'b0;
                    if (spi_done) begin
                        d_out     <= spi_rx;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                // wait for the requester to drop so a held request is not replayed
                DONE: if (!memory_access) state <= IDLE;
                PROG: begin
                    if (!set_programming_mode) begin
                        state     <= IDLE;
                        prog_mode <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    spi_shift_engine #(
        .DATA_W       (DATA_W),
        .SCK_DIV      (SCK_DIV),
        .ADDR_BYTES   (ADDR_BYTES),
        .FAST_READ    (FAST_READ),
        .DUMMY_CYCLES (DUMMY_CYCLES)
    ) u_engine (
        .clk     (clk),
        .rst     (rst),
        .start   (spi_start),
        .addr    (spi_addr),
        .busy    (spi_busy),
        .done    (spi_done),
        .cs_n    (eng_cs_n),
        .sck     (eng_sck),
        .mosi    (eng_mosi),
        .miso    (external_storage_spi_miso),
        .rx_data (spi_rx)
    );

    assign external_storage_spi_cs_n = prog_mode ? programming_spi_cs_n : eng_cs_n;
    assign external_storage_spi_sck  = prog_mode ? programming_spi_sck  : eng_sck;
    assign external_storage_spi_mosi = prog_mode ? programming_spi_mosi : eng_mosi;
    assign programming_spi_miso      = prog_mode & external_storage_spi_miso;

endmodule

// File: tb/tb_spi_storage_controller.sv
// Two controller instances (plain READ/3-byte/div 2 and FAST_READ/4-byte/div 3)
// exercised with random traffic against an SRAM array model and a flash slave model.
module tb_spi_storage_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  acc, wr, spm;
    logic [31:0] ad  [2];
    logic [31:0] din [2];
    logic [3:0]  be  [2];
    logic        p_cs_n, p_sck, p_mosi, miso_ovr, slave_en;

    wire  [1:0]  csw, sckw, mosiw, misow, ov, pmiso;
    wire  [31:0] dout [2];

    int   n_total = 0, n_bad = 0;
    int   ov_cnt [2];
    int   cs_falls [2];
    time  t_csrise [2];
    logic [31:0] model [2048];

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fdata(input logic [31:0] a);
        if (a == 32'h0000_1001) return 32'h1234_5678;
        if (a == 32'h00AB_CDEF) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int AB    = (g == 0) ? 3 : 4;
        localparam int FR    = g;
        localparam int DIV   = (g == 0) ? 2 : 3;
        localparam int DUMMY = (FR != 0) ? 8 : 0;
        localparam int HDR   = 8 + 8 * AB + DUMMY;
        localparam int TOT   = HDR + 32;
        localparam logic [7:0]  OPC   = (FR != 0) ? 8'h0B : 8'h03;
        localparam logic [79:0] AMASK = (80'd1 << (8 * AB)) - 80'd1;

        logic        sbit   = 1'b0;
        logic [79:0] sh     = '0;
        logic [31:0] word   = '0;
        int          rises  = 0;
        time         t_last = 0;

        assign misow[g] = slave_en ? sbit : miso_ovr;

        spi_storage_controller #(
            .DATA_W(32), .SRAM_WORDS(2048), .SCK_DIV(DIV),
            .ADDR_BYTES(AB), .FAST_READ(FR), .DUMMY_CYCLES(8)
        ) dut (
            .clk                       (clk),
            .rst                       (rst),
            .memory_access             (acc[g]),
            .memory_is_writing         (wr[g]),
            .addr                      (ad[g]),
            .d_in                      (din[g]),
            .mem_be                    (be[g]),
            .d_out                     (dout[g]),
            .out_valid                 (ov[g]),
            .set_programming_mode      (spm[g]),
            .external_storage_spi_cs_n (csw[g]),
            .external_storage_spi_sck  (sckw[g]),
            .external_storage_spi_mosi (mosiw[g]),
            .external_storage_spi_miso (misow[g]),
            .programming_spi_cs_n      (p_cs_n),
            .programming_spi_sck       (p_sck),
            .programming_spi_mosi      (p_mosi),
            .programming_spi_miso      (pmiso[g])
        );

        // Behavioural flash: mode 0, serves fdata() of the decoded address.
        always @(negedge csw[g]) if (slave_en && rst) begin
            rises = 0; sh = '0; sbit = 1'b0; t_last = $time; cs_falls[g]++;
        end
        always @(posedge sckw[g]) if (slave_en && rst && !csw[g]) begin
            chk("sck_rise_gap", $time - t_last, DIV * 10);
            t_last = $time;
            sh = {sh[78:0], mosiw[g]};
            rises++;
        end
        always @(negedge sckw[g]) if (slave_en && rst && !csw[g]) begin
            chk("sck_fall_gap", $time - t_last, DIV * 10);
            t_last = $time;
            if (rises == HDR) begin
                chk("frame", sh, ((80'(OPC) << (8 * AB)) | (80'(ad[g]) & AMASK)) << DUMMY);
                word = fdata(32'((sh >> DUMMY) & AMASK));
            end
            if (rises >= HDR && rises < HDR + 32) sbit = word[31 - (rises - HDR)];
        end
        always @(posedge csw[g]) if (slave_en && rst) begin
            chk("cs_tail_gap", $time - t_last, DIV * 10);
            chk("sck_count", rises, TOT);
            t_csrise[g] = $time;
        end
    end

    always @(negedge clk) for (int g = 0; g < 2; g++) if (ov[g]) ov_cnt[g]++;

    task automatic req(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input int hold,
                       output logic [31:0] rd, output int lat, output time tv);
        int c0;
        @(negedge clk);
        c0 = ov_cnt[g];
        ad[g] = a; din[g] = d; be[g] = b; wr[g] = w; acc[g] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov[g] && lat < 3000);
        chk("req_done", ov[g], 1'b1);
        rd = dout[g];
        tv = $time;
        repeat (hold) @(negedge clk);
        acc[g] = 1'b0; wr[g] = 1'b0;
        repeat (2) @(negedge clk);
        chk("ov_pulses", ov_cnt[g] - c0, 1);
    endtask

    task automatic flash_rd(input int g, input logic [31:0] a);
        logic [31:0] rd, m;
        int lat, f0;
        time tv;
        m  = (g == 0) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
        f0 = cs_falls[g];
        req(g, 1'b0, a, 32'h0, 4'h0, 0, rd, lat, tv);
        chk("flash_data", rd, fdata(a & m));
        chk("ov_after_cs", tv - t_csrise[g], 15);
        chk("flash_cs_once", cs_falls[g] - f0, 1);
    endtask

    task automatic ext_wr(input int g, input logic [31:0] a, input int hold);
        logic [31:0] rd;
        int lat, f0;
        time tv;
        f0 = cs_falls[g];
        req(g, 1'b1, a, $urandom, 4'hF, hold, rd, lat, tv);
        chk("ext_wr_lat", lat, 1);
        chk("ext_wr_no_cs", cs_falls[g] - f0, 0);
    endtask

    logic [31:0] a, d, rd;
    logic [3:0]  b;
    int          lat, k, c0;
    time         tv;

    initial begin
        rst = 1'b0; acc = '0; wr = '0; spm = '0;
        p_cs_n = 1'b1; p_sck = 1'b0; p_mosi = 1'b0; miso_ovr = 1'b0; slave_en = 1'b0;
        for (int g = 0; g < 2; g++) begin
            ad[g] = '0; din[g] = '0; be[g] = '0; ov_cnt[g] = 0; cs_falls[g] = 0; t_csrise[g] = 0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_cs_n", csw[g], 1'b1);
            chk("rst_sck", sckw[g], 1'b0);
            chk("rst_mosi", mosiw[g], 1'b0);
            chk("rst_ov", ov[g], 1'b0);
            chk("rst_dout", dout[g], 32'h0);
            chk("rst_pmiso", pmiso[g], 1'b0);
        end
        rst = 1'b1; slave_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 2048; i++) begin
            req(0, 1'b1, i, i, 4'hF, 0, rd, lat, tv);
            chk("sram_wr_lat", lat, 1);
            req(0, 1'b0, i, 32'h0, 4'h0, 0, rd, lat, tv);
            chk("sram_rd_lat", lat, 1);
            chk("sram_rd_data", rd, i);
            model[i] = i;
        end

        req(0, 1'b1, 7, 32'hAABB_CCDD, 4'hF, 0, rd, lat, tv);
        req(0, 1'b1, 7, 32'h1122_3344, 4'b0101, 0, rd, lat, tv);
        req(0, 1'b0, 7, 32'h0, 4'h0, 0, rd, lat, tv);
        chk("byte_enable", rd, 32'hAA22_CC44);
        model[7] = 32'hAA22_CC44;

        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(3, 0);
            case (k)
                0: begin
                    a = $urandom_range(2047, 0); d = $urandom; b = 4'($urandom_range(15, 0));
                    req(0, 1'b1, a, d, b, 0, rd, lat, tv);
                    chk("rnd_wr_lat", lat, 1);
                    for (int j = 0; j < 4; j++) if (b[j]) model[a[10:0]][8*j +: 8] = d[8*j +: 8];
                end
                1: begin
                    a = $urandom_range(2047, 0);
                    req(0, 1'b0, a, 32'h0, 4'h0, 0, rd, lat, tv);
                    chk("rnd_rd_lat", lat, 1);
                    chk("rnd_rd_data", rd, model[a[10:0]]);
                end
                2: flash_rd(0, $urandom_range(32'h00FF_FFFF, 2048));
                default: ext_wr(0, $urandom_range(32'hFFFF_FFFF, 2048), 0);
            endcase
        end

        flash_rd(1, 32'h00AB_CDEF);
        for (int n = 0; n < 4; n++) flash_rd(1, $urandom_range(32'hFFFF_FFFF, 2048));
        d = $urandom;
        req(1, 1'b1, 100, d, 4'hF, 0, rd, lat, tv);
        req(1, 1'b0, 100, 32'h0, 4'h0, 0, rd, lat, tv);
        chk("lane1_sram", rd, d);

        // programming request raised mid-read: read must finish before PROG
        fork
            flash_rd(0, 32'h0000_1001);
            begin repeat (60) @(negedge clk); spm[0] = 1'b1; end
        join
        repeat (2) @(negedge clk);
        slave_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            {p_mosi, p_sck, p_cs_n} = c[2:0];
            #1;
            chk("pt_cs_n", csw[0], c[0]);
            chk("pt_sck", sckw[0], c[1]);
            chk("pt_mosi", mosiw[0], c[2]);
        end
        miso_ovr = 1'b0; #1;
        chk("pt_miso0", pmiso[0], 1'b0);
        miso_ovr = 1'b1; #1;
        chk("pt_miso1", pmiso[0], 1'b1);
        chk("other_lane_miso", pmiso[1], 1'b0);
        c0 = ov_cnt[0];
        @(negedge clk); ad[0] = 32'h5; wr[0] = 1'b0; acc[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("prog_ignores_req", ov_cnt[0] - c0, 0);
        acc[0] = 1'b0; p_cs_n = 1'b1; p_sck = 1'b0; p_mosi = 1'b0;
        @(negedge clk); spm[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_prog_miso", pmiso[0], 1'b0);
        miso_ovr = 1'b0; slave_en = 1'b1;

        ext_wr(0, 32'd2048 + 32'd5, 10);

        @(negedge clk); ad[0] = 32'h0000_5000; wr[0] = 1'b0; acc[0] = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_cs_low", csw[0], 1'b0);
        c0 = ov_cnt[0];
        #2 rst = 1'b0;
        #1;
        chk("async_rst_cs_n", csw[0], 1'b1);
        chk("async_rst_sck", sckw[0], 1'b0);
        acc[0] = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (100) @(negedge clk);
        chk("rst_no_ov", ov_cnt[0] - c0, 0);
        chk("rst_cs_idle", csw[0], 1'b1);
        req(0, 1'b1, 9, 32'h0BAD_F00D, 4'hF, 0, rd, lat, tv);
        chk("post_rst_lat", lat, 1);
        req(0, 1'b0, 9, 32'h0, 4'h0, 0, rd, lat, tv);
        chk("post_rst_data", rd, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
